// File: rtl/channel_read_scheduler.sv
// Round-robin burst reader: arbitrates among three channel FIFOs and streams
// one header word plus BURST_LEN samples per frame to the com FPGA.
module channel_read_scheduler #(
    parameter int          BURST_LEN = 128,
    parameter logic [15:0] HEADER    = 16'hA5A0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fifo_full_1,
    input  logic        fifo_full_2,
    input  logic        fifo_full_3,
    input  logic [15:0] data_ch_1,
    input  logic [15:0] data_ch_2,
    input  logic [15:0] data_ch_3,
    input  logic        host_ready,
    output logic        rdreq_1,
    output logic        rdreq_2,
    output logic        rdreq_3,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic        frame_end,
    output logic        busy
);
    localparam int             CW       = $clog2(BURST_LEN + 1);
    localparam logic [CW-1:0]  LAST_CNT = CW'(BURST_LEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_HEADER, S_READ, S_DRAIN} state_t;

    state_t        state, state_nxt;
    logic [1:0]    sel, sel_nxt;
    logic [1:0]    last_served, last_nxt;
    logic [CW-1:0] word_cnt, cnt_nxt;
    logic          hdr_load;
    logic          rd_any;
    logic          rd_d1, last_d1;
    logic [2:0]    full;
    logic          arb_hit;
    logic [1:0]    arb_ch;
    logic [15:0]   q_sel;

    assign full   = {fifo_full_3, fifo_full_2, fifo_full_1};
    assign rd_any = (state == S_READ) && host_ready;
    assign rdreq_1 = rd_any && (sel == 2'd1);
    assign rdreq_2 = rd_any && (sel == 2'd2);
    assign rdreq_3 = rd_any && (sel == 2'd3);
    assign busy   = (state != S_IDLE);

    // Search starts at the channel after last_served; channel n lives at full[n-1].
    always_comb begin
        arb_hit = 1'b0;
        arb_ch  = 2'd1;
        for (int k = 0; k < 3; k++) begin
            int idx;
            idx = (int'(last_served) + k) % 3;
            if (!arb_hit && full[idx]) begin
                arb_hit = 1'b1;
                arb_ch  = 2'(idx + 1);
            end
        end
    end

    always_comb begin
        case (sel)
            2'd1:    q_sel = data_ch_1;
            2'd2:    q_sel = data_ch_2;
            default: q_sel = data_ch_3;
        endcase
    end

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        last_nxt  = last_served;
        cnt_nxt   = word_cnt;
        hdr_load  = 1'b0;
        case (state)
            S_IDLE: begin
                if (arb_hit) begin
                    sel_nxt   = arb_ch;
                    state_nxt = S_HEADER;
                end
            end
            S_HEADER: begin
                if (host_ready) begin
                    hdr_load  = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = S_READ;
                end
            end
            S_READ: begin
                if (host_ready) begin
                    cnt_nxt = word_cnt + 1'b1;
                    if (word_cnt == LAST_CNT) state_nxt = S_DRAIN;
                end
            end
            default: begin
                // Last read's q is registered this cycle once rd_d1 clears.
                if (!rd_d1) begin
                    last_nxt  = sel;
                    state_nxt = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            sel         <= 2'd1;
            last_served <= 2'd3;
            word_cnt    <= '0;
            rd_d1       <= 1'b0;
            last_d1     <= 1'b0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            frame_end   <= 1'b0;
        end else begin
            state       <= state_nxt;
            sel         <= sel_nxt;
            last_served <= last_nxt;
            word_cnt    <= cnt_nxt;
            rd_d1       <= rd_any;
            last_d1     <= rd_any && (word_cnt == LAST_CNT);
            data_valid  <= hdr_load | rd_d1;
            frame_end   <= last_d1;
            if (hdr_load)
                data_out <= {HEADER[15:4], 2'b00, sel};
            else if (rd_d1)
                data_out <= q_sel;
        end
    end
endmodule

// File: doc/channel_read_scheduler.md
CHANNEL_READ_SCHEDULER -- requirements
Module: channel_read_scheduler

Interface
REQ-001 Parameter: BURST_LEN, 128, words read from the selected channel FIFO per frame (range 2..1024).
REQ-002 Parameter: HEADER, 16'hA5A0, frame header base; channel ID is inserted in bits [3:0].
REQ-003 Port: clk  input  1  single clock for all logic.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: fifo_full_1, fifo_full_2, fifo_full_3  input  1 each  channel FIFO has a burst ready.
REQ-006 Port: data_ch_1, data_ch_2, data_ch_3  input  16 each  channel FIFO q; valid 1 cycle after rdreq.
REQ-007 Port: host_ready  input  1  the com FPGA can accept words; low applies back-pressure.
REQ-008 Port: rdreq_1, rdreq_2, rdreq_3  output  1 each  read strobe to the channel FIFOs.
REQ-009 Port: data_out  output  16  registered header or sample word to the com FPGA.
REQ-010 Port: data_valid  output  1  data_out is valid this cycle.
REQ-011 Port: frame_end  output  1  one-cycle pulse coincident with the last word of a frame.
REQ-012 Port: busy  output  1  high whenever state is not IDLE.

Function
REQ-013 FSM states SHALL be IDLE, HEADER, READ and DRAIN.
REQ-014 IDLE: if any fifo_full_n is high, the block SHALL select a channel round-robin, starting from the channel after last_served, and go to HEADER on the next cycle.
REQ-015 Round-robin order SHALL be 1 -> 2 -> 3 -> 1; last_served resets to 3, so channel 1 has first priority.
REQ-016 HEADER: the cycle host_ready is high, the block SHALL register data_out = {HEADER[15:4], ch_id[3:0]} (ch_id 1..3) with data_valid=1, then go to READ with word_cnt=0.
REQ-017 HEADER with host_ready low: the block SHALL stay in HEADER and hold data_valid=0.
REQ-018 READ: rdreq of the selected channel SHALL equal host_ready (combinational); all other rdreq SHALL be 0.
REQ-019 word_cnt SHALL increment on each asserted rdreq.
REQ-020 The rdreq that brings word_cnt to BURST_LEN SHALL be the last; the FSM then moves to DRAIN.
REQ-021 Data pipeline: for rdreq at cycle t, the FIFO q at t+1 SHALL be registered into data_out with data_valid=1 at t+2.
REQ-022 Back-pressure: when host_ready falls, rdreq SHALL stop in that cycle; up to 2 words already in flight SHALL still emerge.
REQ-023 Each frame SHALL contain exactly 1 header word plus BURST_LEN data words.
REQ-024 frame_end SHALL pulse with the data_valid of data word BURST_LEN.
REQ-025 DRAIN: the FSM SHALL wait until the pipeline is empty (2 cycles), update last_served to the served channel, then return to IDLE.
REQ-026 fifo_full of the served channel deasserting mid-burst SHALL be ignored; the burst completes, and FIFO empty is not checked.
REQ-027 fifo_full of other channels during a frame SHALL be ignored until IDLE re-arbitrates; requests are level-sensitive, so none are lost.
REQ-028 word_cnt width SHALL be clog2(BURST_LEN+1) bits, with no wrap inside a frame.
REQ-029 Consecutive frames SHALL be separated by at least 1 IDLE cycle (no data_valid in that cycle).

Reset
REQ-030 While rst_n=0: state=IDLE, last_served=3, word_cnt=0, and all rdreq, data_out, data_valid, frame_end and busy SHALL be 0.
REQ-031 Reset asserted mid-frame SHALL abort the frame immediately, discard in-flight words and leave no partial frame_end.
REQ-032 After release, behaviour SHALL restart from IDLE with channel 1 as first priority.

Verification
REQ-033 BURST_LEN=4, fifo_full_2=1 only, host_ready=1 -> data_out: 16'hA5A2 followed by 4 rdreq_2 words; frame_end on word 4; busy returns to 0.
REQ-034 All three fifo_full held high, host_ready=1 -> frames for channels 1, 2, 3, 1 in order; headers A5A1, A5A2, A5A3, A5A1.
REQ-035 host_ready low for 5 cycles mid-READ -> rdreq_n low in exactly those cycles; at most 2 words valid after the fall; total data words still BURST_LEN with no duplicates or gaps.
REQ-036 rst_n pulsed low during word 2 of a channel 3 frame -> all outputs 0 asynchronously; next frame starts with channel 1 if fifo_full_1 is high.
REQ-037 fifo_full_1 drops after the first rdreq -> exactly BURST_LEN rdreq_1 still issued; no other rdreq asserted during the frame.
